// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences the shared memory, ALU and IR over several
// cycles per instruction, with fixed-latency or handshake memory timing.
//
// state    | meaning
// ---------+----------------------------------------------------------
// FETCH    | read instruction at PC, PC+4; IR and PC load on mem_done
// DECODE   | branch target PC+(imm<<2) into ALUOut, dispatch on opcode
// MEMADR   | A + sign-ext imm -> ALUOut (lw/sw address)
// MEMRD    | read data at ALUOut into MDR
// MEMWB    | MDR -> rt
// MEMWR    | write B at ALUOut, held until mem_done
// RTYPE_EX | A funct B -> ALUOut
// ALU_WB   | ALUOut -> rd
// BRANCH   | A - B, PC <= ALUOut on zero (beq) / non-zero (bne)
// JUMP     | PC <= jump target
// IMM_EX   | A op sign-ext imm -> ALUOut
// JAL      | PC <= jump target, r31 <= PC (already PC+4)
// JR       | PC <= A
// ILLEGAL  | trap, held until reset
// IMM_WB   | ALUOut -> rt
module mips_multicycle_control #(
    parameter bit          USE_READY   = 1'b0,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCWriteCondNe,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic [1:0] PCSource,
    output logic [2:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       RegWrite,
    output logic       Illegal,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMRD    = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWR    = 4'd5,
        S_RTYPE_EX = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_IMM_EX   = 4'd10,
        S_JAL      = 4'd11,
        S_JR       = 4'd12,
        S_ILLEGAL  = 4'd13,
        S_IMM_WB   = 4'd14,
        S_UNUSED   = 4'd15
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(MEM_LATENCY - 1);

    state_t     state, state_next;
    logic [3:0] cnt;
    logic       mem_done;
    logic       is_mem;

    assign is_mem   = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
    assign mem_done = USE_READY ? Mem_ready : (cnt == CNT_LAST);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= S_FETCH;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            // the counter restarts on every state change, so each memory state sees 0 on entry
            if (state_next != state)
                cnt <= 4'd0;
            else if (!USE_READY && is_mem && !mem_done)
                cnt <= cnt + 4'd1;
        end
    end

    always_comb begin
        state_next    = state;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCWriteCondNe = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        PCSource      = 2'b00;
        ALUOp         = 3'b000;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        RegWrite      = 1'b0;
        Illegal       = 1'b0;

        case (state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_done) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    6'h00:                      state_next = (funct == 6'h08) ? S_JR : S_RTYPE_EX;
                    6'h23, 6'h2B:               state_next = S_MEMADR;
                    6'h04, 6'h05:               state_next = S_BRANCH;
                    6'h08, 6'h0C, 6'h0D, 6'h0A: state_next = S_IMM_EX;
                    6'h02:                      state_next = S_JUMP;
                    6'h03:                      state_next = S_JAL;
                    default:                    state_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                state_next = (opcode == 6'h23) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_done)
                    state_next = S_MEMWB;
            end
            S_MEMWB: begin
                MemtoReg   = 2'b01;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_done)
                    state_next = S_FETCH;
            end
            S_RTYPE_EX: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 3'b010;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                RegDst     = 2'b01;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUOp         = 3'b001;
                PCSource      = 2'b01;
                PCWriteCond   = (opcode == 6'h04);
                PCWriteCondNe = (opcode == 6'h05);
                state_next    = S_FETCH;
            end
            S_JUMP: begin
                PCSource   = 2'b10;
                PCWrite    = 1'b1;
                state_next = S_FETCH;
            end
            S_IMM_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (opcode)
                    6'h0C:   ALUOp = 3'b011;
                    6'h0D:   ALUOp = 3'b100;
                    6'h0A:   ALUOp = 3'b101;
                    default: ALUOp = 3'b000;
                endcase
                state_next = S_IMM_WB;
            end
            S_IMM_WB: begin
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                PCSource   = 2'b10;
                PCWrite    = 1'b1;
                RegDst     = 2'b10;
                MemtoReg   = 2'b10;
                RegWrite   = 1'b1;
                state_next = S_FETCH;
            end
            S_JR: begin
                PCSource   = 2'b11;
                PCWrite    = 1'b1;
                state_next = S_FETCH;
            end
            S_ILLEGAL: begin
                Illegal    = 1'b1;
                state_next = S_ILLEGAL;
            end
            default: state_next = S_ILLEGAL;
        endcase
    end

    assign State = state;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: three instances (latency 1, latency 3,
// ready handshake) share stimulus; each scenario queues expected outputs per cycle.
module tb_mips_multicycle_control;

    typedef logic [24:0] ov_t;
    typedef struct {
        logic rdy;
        ov_t  exp;
    } sb_t;

    // {State, PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite,
    //  RegDst, MemtoReg, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, Illegal}
    localparam ov_t F_ILL    = 25'd1 << 0;
    localparam ov_t F_RW     = 25'd1 << 1;
    localparam ov_t F_SA     = 25'd1 << 4;
    localparam ov_t F_IRW    = 25'd1 << 14;
    localparam ov_t F_MW     = 25'd1 << 15;
    localparam ov_t F_MR     = 25'd1 << 16;
    localparam ov_t F_IORD   = 25'd1 << 17;
    localparam ov_t F_PCWCNE = 25'd1 << 18;
    localparam ov_t F_PCWC   = 25'd1 << 19;
    localparam ov_t F_PCW    = 25'd1 << 20;

    localparam ov_t FETCH_WAIT = F_MR | (25'd1 << 2);
    localparam ov_t FETCH_DONE = FETCH_WAIT | F_IRW | F_PCW;
    localparam ov_t DECODE     = (25'd1 << 21) | (25'd3 << 2);
    localparam ov_t MEMADR     = (25'd2 << 21) | F_SA | (25'd2 << 2);
    localparam ov_t MEMWR      = (25'd5 << 21) | F_MW | F_IORD;
    localparam ov_t ILL        = (25'd13 << 21) | F_ILL;

    function automatic ov_t fst(input int n);  return ov_t'(n) << 21; endfunction
    function automatic ov_t frd(input int n);  return ov_t'(n) << 12; endfunction
    function automatic ov_t fmtr(input int n); return ov_t'(n) << 10; endfunction
    function automatic ov_t fpcs(input int n); return ov_t'(n) << 8;  endfunction
    function automatic ov_t fop(input int n);  return ov_t'(n) << 5;  endfunction
    function automatic ov_t fsb(input int n);  return ov_t'(n) << 2;  endfunction

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [5:0] opcode = 6'h00;
    logic [5:0] funct = 6'h00;
    logic       mem_ready = 1'b0;

    logic [2:0] pcw, pcwc, pcwcne, iord, mr, mw, irw, sa, rw, ill;
    logic [1:0] regdst [3];
    logic [1:0] mtr [3];
    logic [1:0] pcs [3];
    logic [2:0] aluop [3];
    logic [1:0] sb [3];
    logic [3:0] st [3];
    ov_t        obs [3];

    sb_t q[$];
    int  n_pass = 0;
    int  n_total = 0;

    always #5 CLK = ~CLK;

    mips_multicycle_control #(.USE_READY(1'b0), .MEM_LATENCY(1)) u_l1 (
        .CLK(CLK), .RESET(RESET), .opcode(opcode), .funct(funct), .Mem_ready(mem_ready),
        .PCWrite(pcw[0]), .PCWriteCond(pcwc[0]), .PCWriteCondNe(pcwcne[0]), .IorD(iord[0]),
        .MemRead(mr[0]), .MemWrite(mw[0]), .IRWrite(irw[0]), .RegDst(regdst[0]),
        .MemtoReg(mtr[0]), .PCSource(pcs[0]), .ALUOp(aluop[0]), .ALUSrcA(sa[0]),
        .ALUSrcB(sb[0]), .RegWrite(rw[0]), .Illegal(ill[0]), .State(st[0]));

    mips_multicycle_control #(.USE_READY(1'b0), .MEM_LATENCY(3)) u_l3 (
        .CLK(CLK), .RESET(RESET), .opcode(opcode), .funct(funct), .Mem_ready(mem_ready),
        .PCWrite(pcw[1]), .PCWriteCond(pcwc[1]), .PCWriteCondNe(pcwcne[1]), .IorD(iord[1]),
        .MemRead(mr[1]), .MemWrite(mw[1]), .IRWrite(irw[1]), .RegDst(regdst[1]),
        .MemtoReg(mtr[1]), .PCSource(pcs[1]), .ALUOp(aluop[1]), .ALUSrcA(sa[1]),
        .ALUSrcB(sb[1]), .RegWrite(rw[1]), .Illegal(ill[1]), .State(st[1]));

    mips_multicycle_control #(.USE_READY(1'b1), .MEM_LATENCY(1)) u_rdy (
        .CLK(CLK), .RESET(RESET), .opcode(opcode), .funct(funct), .Mem_ready(mem_ready),
        .PCWrite(pcw[2]), .PCWriteCond(pcwc[2]), .PCWriteCondNe(pcwcne[2]), .IorD(iord[2]),
        .MemRead(mr[2]), .MemWrite(mw[2]), .IRWrite(irw[2]), .RegDst(regdst[2]),
        .MemtoReg(mtr[2]), .PCSource(pcs[2]), .ALUOp(aluop[2]), .ALUSrcA(sa[2]),
        .ALUSrcB(sb[2]), .RegWrite(rw[2]), .Illegal(ill[2]), .State(st[2]));

    always_comb begin
        for (int i = 0; i < 3; i++)
            obs[i] = {st[i], pcw[i], pcwc[i], pcwcne[i], iord[i], mr[i], mw[i], irw[i],
                      regdst[i], mtr[i], pcs[i], aluop[i], sa[i], sb[i], rw[i], ill[i]};
    end

    function automatic void push(input logic r, input ov_t x);
        q.push_back('{r, x});
    endfunction

    // drives Mem_ready for the current cycle, samples mid-cycle, advances to next negedge
    task automatic sample(input int k, input logic rdy, output ov_t got);
        mem_ready = rdy;
        #1;
        got = obs[k];
        @(negedge CLK);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    task automatic test_reset();
        sb_t e;
        do_reset();
        mem_ready = 1'b0;
        push(1'b0, FETCH_DONE);
        push(1'b0, FETCH_WAIT);
        push(1'b0, FETCH_WAIT);
        #1;
        for (int k = 0; k < 3; k++) begin
            e = q.pop_front();
            n_total++;
            if (obs[k] !== e.exp) $display("FAIL reset inst%0d: got %h, want %h", k, obs[k], e.exp);
            else n_pass++;
        end
        @(negedge CLK);
    endtask

    task automatic test_lw();
        ov_t got;
        sb_t e;
        do_reset();
        opcode = 6'h23;
        funct  = 6'h00;
        push(1'b0, FETCH_DONE);
        push(1'b0, DECODE);
        push(1'b0, MEMADR);
        push(1'b0, fst(3) | F_MR | F_IORD);
        push(1'b0, fst(4) | fmtr(1) | F_RW);
        push(1'b0, FETCH_DONE);
        for (int c = 0; q.size() > 0; c++) begin
            e = q.pop_front();
            sample(0, e.rdy, got);
            n_total++;
            if (got !== e.exp) $display("FAIL lw cyc%0d: got %h, want %h", c, got, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_sw_ready();
        ov_t got;
        sb_t e;
        do_reset();
        opcode = 6'h2B;
        push(1'b1, FETCH_DONE);
        push(1'b0, DECODE);
        push(1'b0, MEMADR);
        push(1'b0, MEMWR);
        push(1'b0, MEMWR);
        push(1'b0, MEMWR);
        push(1'b1, MEMWR);
        push(1'b0, FETCH_WAIT);
        for (int c = 0; q.size() > 0; c++) begin
            e = q.pop_front();
            sample(2, e.rdy, got);
            n_total++;
            if (got !== e.exp) $display("FAIL sw_ready cyc%0d: got %h, want %h", c, got, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_rtype_lat3();
        ov_t got;
        sb_t e;
        do_reset();
        opcode = 6'h00;
        funct  = 6'h20;
        push(1'b0, FETCH_WAIT);
        push(1'b0, FETCH_WAIT);
        push(1'b0, FETCH_DONE);
        push(1'b0, DECODE);
        push(1'b0, fst(6) | F_SA | fop(2));
        push(1'b0, fst(7) | frd(1) | F_RW);
        push(1'b0, FETCH_WAIT);
        for (int c = 0; q.size() > 0; c++) begin
            e = q.pop_front();
            sample(1, e.rdy, got);
            n_total++;
            if (got !== e.exp) $display("FAIL rtype_lat3 cyc%0d: got %h, want %h", c, got, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_branch_jump();
        logic [5:0] ops [4];
        ov_t        exec [4];
        ov_t        got;
        sb_t        e;
        ops[0] = 6'h05; exec[0] = fst(8) | F_SA | fop(1) | fpcs(1) | F_PCWCNE;
        ops[1] = 6'h04; exec[1] = fst(8) | F_SA | fop(1) | fpcs(1) | F_PCWC;
        ops[2] = 6'h03; exec[2] = fst(11) | fpcs(2) | F_PCW | frd(2) | fmtr(2) | F_RW;
        ops[3] = 6'h02; exec[3] = fst(9) | fpcs(2) | F_PCW;
        do_reset();
        funct = 6'h00;
        for (int i = 0; i < 4; i++) begin
            opcode = ops[i];
            push(1'b0, FETCH_DONE);
            push(1'b0, DECODE);
            push(1'b0, exec[i]);
            for (int c = 0; q.size() > 0; c++) begin
                e = q.pop_front();
                sample(0, e.rdy, got);
                n_total++;
                if (got !== e.exp)
                    $display("FAIL branch_jump op%h cyc%0d: got %h, want %h", ops[i], c, got, e.exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_jr_imm();
        logic [5:0] ops [5];
        ov_t        got;
        sb_t        e;
        ops[0] = 6'h00; ops[1] = 6'h08; ops[2] = 6'h0C; ops[3] = 6'h0D; ops[4] = 6'h0A;
        do_reset();
        funct = 6'h08;
        for (int i = 0; i < 5; i++) begin
            opcode = ops[i];
            push(1'b0, FETCH_DONE);
            push(1'b0, DECODE);
            case (i)
                0: push(1'b0, fst(12) | fpcs(3) | F_PCW);
                1: push(1'b0, fst(10) | F_SA | fsb(2) | fop(0));
                2: push(1'b0, fst(10) | F_SA | fsb(2) | fop(3));
                3: push(1'b0, fst(10) | F_SA | fsb(2) | fop(4));
                default: push(1'b0, fst(10) | F_SA | fsb(2) | fop(5));
            endcase
            if (i != 0) push(1'b0, fst(14) | F_RW);
            for (int c = 0; q.size() > 0; c++) begin
                e = q.pop_front();
                sample(0, e.rdy, got);
                n_total++;
                if (got !== e.exp)
                    $display("FAIL jr_imm op%h cyc%0d: got %h, want %h", ops[i], c, got, e.exp);
                else n_pass++;
            end
        end
    endtask

    task automatic test_illegal();
        ov_t got;
        sb_t e;
        do_reset();
        opcode = 6'h3F;
        funct  = 6'h00;
        push(1'b0, FETCH_DONE);
        push(1'b0, DECODE);
        for (int i = 0; i < 20; i++) push(1'($urandom_range(0, 1)), ILL);
        for (int c = 0; q.size() > 0; c++) begin
            e = q.pop_front();
            if (c >= 2) begin
                opcode = 6'($urandom);
                funct  = 6'($urandom);
            end
            sample(0, e.rdy, got);
            n_total++;
            if (got !== e.exp) $display("FAIL illegal cyc%0d: got %h, want %h", c, got, e.exp);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        ov_t got;
        sb_t e;
        // u_l1 is still trapped from the previous scenario
        mem_ready = 1'b0;
        push(1'b0, ILL);
        push(1'b0, FETCH_DONE);
        #2;
        e = q.pop_front();
        n_total++;
        if (obs[0] !== e.exp) $display("FAIL pre_reset_illegal: got %h, want %h", obs[0], e.exp);
        else n_pass++;
        RESET = 1'b0;
        #1;
        e = q.pop_front();
        n_total++;
        if (obs[0] !== e.exp) $display("FAIL async_reset_illegal: got %h, want %h", obs[0], e.exp);
        else n_pass++;
        @(negedge CLK);
        RESET  = 1'b1;
        opcode = 6'h2B;
        push(1'b0, FETCH_WAIT);
        push(1'b0, FETCH_WAIT);
        push(1'b0, FETCH_DONE);
        push(1'b0, DECODE);
        push(1'b0, MEMADR);
        push(1'b0, MEMWR);
        for (int c = 0; q.size() > 0; c++) begin
            e = q.pop_front();
            sample(1, e.rdy, got);
            n_total++;
            if (got !== e.exp) $display("FAIL sw_lat3 cyc%0d: got %h, want %h", c, got, e.exp);
            else n_pass++;
        end
        // now in the second MEMWR cycle of u_l3
        push(1'b0, MEMWR);
        push(1'b0, FETCH_WAIT);
        push(1'b0, FETCH_WAIT);
        push(1'b0, FETCH_DONE);
        #2;
        e = q.pop_front();
        n_total++;
        if (obs[1] !== e.exp) $display("FAIL pre_reset_memwr: got %h, want %h", obs[1], e.exp);
        else n_pass++;
        RESET = 1'b0;
        #1;
        e = q.pop_front();
        n_total++;
        if (obs[1] !== e.exp) $display("FAIL async_reset_memwr: got %h, want %h", obs[1], e.exp);
        else n_pass++;
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        e = q.pop_front();
        n_total++;
        if (obs[1] !== e.exp) $display("FAIL post_release_l3: got %h, want %h", obs[1], e.exp);
        else n_pass++;
        e = q.pop_front();
        n_total++;
        if (obs[0] !== e.exp) $display("FAIL post_release_l1: got %h, want %h", obs[0], e.exp);
        else n_pass++;
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_lw();
        test_sw_ready();
        test_rtype_lat3();
        test_branch_jump();
        test_jr_imm();
        test_illegal();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle successor to the single-cycle Control decoder.
- A Moore/Mealy FSM sequences one shared memory, one ALU and the instruction register across several cycles per instruction.
- Parametrised memory wait behaviour: fixed latency or Mem_ready handshake.
- Adds bne, jal, jr and illegal-opcode trapping; drives the multi-cycle datapath's muxes and write enables.

Parameters:
USE_READY, 0, 0 = memory access completes after MEM_LATENCY cycles; 1 = completes on the cycle Mem_ready is sampled high
MEM_LATENCY, 1, cycles per memory access when USE_READY=0 (legal range 1..15)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
opcode  in  6  IR[31:26], held by the datapath IR
funct  in  6  IR[5:0]
Mem_ready  in  1  memory done (used only when USE_READY=1)
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if ALU_zero (beq)
PCWriteCondNe  out  1  PC load if !ALU_zero (bne)
IorD  out  1  0 = PC addresses memory; 1 = ALUOut addresses memory
MemRead  out  1  memory read
MemWrite  out  1  memory write
IRWrite  out  1  IR load
RegDst  out  2  00 rt, 01 rd, 10 r31
MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC
PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target, 11 register A
ALUOp  out  3  000 add, 001 sub, 010 funct, 011 and, 100 or, 101 slt
ALUSrcA  out  1  0 PC, 1 A
ALUSrcB  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
RegWrite  out  1  register file write
Illegal  out  1  sticky trap flag
State  out  4  current state, for debug

Behaviour:
- Reset: RESET low forces State to FETCH(0), the wait counter to 0 and Illegal to 0 immediately. All outputs are decoded from state, so MemWrite drops at once if reset hits mid-MEMWR.
- Default for every output is 0. Each state below lists only the outputs it drives non-zero.
- mem_done definition:
  - USE_READY=1: mem_done = Mem_ready.
  - USE_READY=0: mem_done = (cnt == MEM_LATENCY-1).
  - cnt is 4 bits. It clears on entry to every memory state, increments while waiting, and never wraps because the legal range is 1..15.
- States and transitions:
  - FETCH(0): MemRead, ALUSrcB=01. On mem_done, also IRWrite=1 and PCWrite=1 in that same cycle, then go to DECODE. Otherwise stay in FETCH.
  - DECODE(1): ALUSrcB=11 (branch target computed into ALUOut). Next state by opcode:
    - 0x00 with funct 0x08 → JR; other 0x00 → RTYPE_EX
    - 0x23 or 0x2B → MEMADR
    - 0x04 or 0x05 → BRANCH
    - 0x08, 0x0C, 0x0D, 0x0A → IMM_EX
    - 0x02 → JUMP; 0x03 → JAL
    - anything else → ILLEGAL
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10. Goes to MEMRD if opcode=0x23, else MEMWR.
  - MEMRD(3): MemRead, IorD. On mem_done → MEMWB.
  - MEMWB(4): MemtoReg=01, RegWrite → FETCH.
  - MEMWR(5): MemWrite, IorD, held for the whole wait. On mem_done → FETCH.
  - RTYPE_EX(6): ALUSrcA=1, ALUOp=010 → ALU_WB.
  - ALU_WB(7): RegDst=01, RegWrite → FETCH.
  - BRANCH(8): ALUSrcA=1, ALUOp=001, PCSource=01. Drives PCWriteCond if opcode=0x04, PCWriteCondNe if opcode=0x05 → FETCH.
  - JUMP(9): PCSource=10, PCWrite → FETCH.
  - IMM_EX(10): ALUSrcA=1, ALUSrcB=10. ALUOp is 000 for 0x08, 011 for 0x0C, 100 for 0x0D, 101 for 0x0A → IMM_WB.
  - IMM_WB(14): RegDst=00, MemtoReg=00, RegWrite → FETCH.
  - JAL(11): PCSource=10, PCWrite, RegDst=10, MemtoReg=10, RegWrite, all in one cycle. The link value is the PC already incremented in FETCH. → FETCH.
  - JR(12): PCSource=11, PCWrite → FETCH.
  - ILLEGAL(13): Illegal=1, all other outputs 0. Stays until RESET.
- Encoding 15 is unreachable. If entered, next state is ILLEGAL.
- Cycle counts with L = access latency: R-type/imm L+3, lw 2L+3, sw 2L+2, branch/j/jal/jr L+2.
- Write enables (RegWrite, PCWrite, PCWriteCond, PCWriteCondNe, IRWrite, MemWrite) are never asserted in two consecutive instructions' states, except as listed above.

Test Plan:
- USE_READY=0, MEM_LATENCY=1, opcode=0x23 → State sequence 0,1,2,3,4,0. RegWrite=1 with MemtoReg=01 only in state 4. Total 5 cycles.
- USE_READY=1, opcode=0x2B, Mem_ready low 3 cycles in MEMWR then high → MemWrite high exactly 4 cycles with IorD=1, then FETCH.
- MEM_LATENCY=3, opcode=0x00, funct=0x20 → FETCH lasts 3 cycles. IRWrite and PCWrite pulse only in the 3rd. ALU_WB has RegDst=01. Total 6 cycles.
- opcode=0x05 → BRANCH: PCWriteCondNe=1, PCWriteCond=0, ALUOp=001, PCSource=01 for 1 cycle. opcode=0x03 → JAL: PCWrite=RegWrite=1, RegDst=10, MemtoReg=10 in a single cycle.
- opcode=0x00, funct=0x08 → JR with PCSource=11, PCWrite=1. opcode=0x3F → ILLEGAL; Illegal stays 1 for 20 cycles of any input.
- Assert RESET low asynchronously mid-MEMWR and mid-ILLEGAL → State=0, MemWrite=0 and Illegal=0 before the next CLK edge. After release, FETCH outputs MemRead=1, ALUSrcB=01.
